// File: rtl/adsr_phase_controller.sv
// ADSR envelope sequencer: walks IDLE/ATTACK/DECAY/SUSTAIN/RELEASE from a note gate,
// pacing each phase's level steps with a reloadable countdown divider driven by tick.
module adsr_phase_controller #(
  parameter int LEVEL_W = 4,
  parameter int RATE_W  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               gate,
  input  logic [RATE_W-1:0]  attack_rate,
  input  logic [RATE_W-1:0]  decay_rate,
  input  logic [LEVEL_W-1:0] sustain_level,
  input  logic [RATE_W-1:0]  release_rate,
  output logic [LEVEL_W-1:0] level,
  output logic [2:0]         phase,
  output logic               active,
  output logic               done
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } phase_t;

  localparam logic [LEVEL_W-1:0] LMAX   = {LEVEL_W{1'b1}};
  localparam logic [LEVEL_W-1:0] LZERO  = {LEVEL_W{1'b0}};
  localparam logic [RATE_W-1:0]  DZERO  = {RATE_W{1'b0}};

  phase_t             r_phase;
  logic [LEVEL_W-1:0] r_level;
  logic [RATE_W-1:0]  r_div;
  logic               r_gate_q;
  logic               r_active;
  logic               r_done;

  phase_t             w_phase_nxt;
  logic [LEVEL_W-1:0] w_level_nxt;
  logic [RATE_W-1:0]  w_div_nxt;
  logic               w_done_nxt;
  logic               w_rise;
  logic               w_fall;
  logic               w_gated_phase;
  logic [LEVEL_W-1:0] w_level_inc;
  logic [LEVEL_W-1:0] w_level_dec;
  logic [RATE_W-1:0]  w_div_dec;

  assign w_rise        = gate & ~r_gate_q;
  assign w_fall        = ~gate & r_gate_q;
  assign w_gated_phase = (r_phase == ST_ATTACK) || (r_phase == ST_DECAY) ||
                         (r_phase == ST_SUSTAIN);
  assign w_level_inc   = r_level + LEVEL_W'(1);
  assign w_level_dec   = r_level - LEVEL_W'(1);
  assign w_div_dec     = r_div - RATE_W'(1);

  // Next-state: gate edges win over tick, so a coincident tick never moves the level.
  always_comb begin
    w_phase_nxt = r_phase;
    w_level_nxt = r_level;
    w_div_nxt   = r_div;
    w_done_nxt  = 1'b0;
    if (w_rise) begin
      w_phase_nxt = ST_ATTACK;
      w_div_nxt   = attack_rate;
    end else if (w_fall && w_gated_phase) begin
      w_phase_nxt = ST_RELEASE;
      w_div_nxt   = release_rate;
    end else if (tick) begin
      case (r_phase)
        ST_IDLE: begin
          w_level_nxt = LZERO;
        end
        ST_ATTACK: begin
          if (r_div != DZERO) begin
            w_div_nxt = w_div_dec;
          end else if (r_level == LMAX) begin
            w_phase_nxt = ST_DECAY;
            w_div_nxt   = decay_rate;
          end else if (w_level_inc == LMAX) begin
            w_level_nxt = w_level_inc;
            w_phase_nxt = ST_DECAY;
            w_div_nxt   = decay_rate;
          end else begin
            w_level_nxt = w_level_inc;
            w_div_nxt   = attack_rate;
          end
        end
        ST_DECAY: begin
          if (r_div != DZERO) begin
            w_div_nxt = w_div_dec;
          end else if (r_level > sustain_level) begin
            w_level_nxt = w_level_dec;
            w_div_nxt   = decay_rate;
            if (w_level_dec == sustain_level) begin
              w_phase_nxt = ST_SUSTAIN;
            end else begin
              w_phase_nxt = ST_DECAY;
            end
          end else begin
            w_phase_nxt = ST_SUSTAIN;
            w_div_nxt   = decay_rate;
          end
        end
        ST_SUSTAIN: begin
          w_level_nxt = sustain_level;
        end
        ST_RELEASE: begin
          if (r_div != DZERO) begin
            w_div_nxt = w_div_dec;
          end else if ((r_level == LZERO) || (w_level_dec == LZERO)) begin
            w_level_nxt = LZERO;
            w_phase_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
            w_div_nxt   = release_rate;
          end else begin
            w_level_nxt = w_level_dec;
            w_div_nxt   = release_rate;
          end
        end
        default: begin
          w_phase_nxt = ST_IDLE;
          w_level_nxt = LZERO;
          w_div_nxt   = DZERO;
        end
      endcase
    end else begin
      w_phase_nxt = r_phase;
    end
  end

  // State and registered outputs; reset aborts any envelope without a done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_phase  <= ST_IDLE;
      r_level  <= LZERO;
      r_div    <= DZERO;
      r_gate_q <= 1'b0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_phase  <= w_phase_nxt;
      r_level  <= w_level_nxt;
      r_div    <= w_div_nxt;
      r_gate_q <= gate;
      r_active <= (w_phase_nxt != ST_IDLE);
      r_done   <= w_done_nxt;
    end
  end

  assign level  = r_level;
  assign phase  = r_phase;
  assign active = r_active;
  assign done   = r_done;

endmodule

// File: tb/tb_adsr_phase_controller.sv
// Self-checking bench for adsr_phase_controller: directed scenarios plus random gate/tick
// traffic, all compared every cycle against a behavioural envelope model.
module tb_adsr_phase_controller;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       gate;
  logic [3:0] attack_rate;
  logic [3:0] decay_rate;
  logic [3:0] sustain_level;
  logic [3:0] release_rate;
  logic [3:0] level;
  logic [2:0] phase;
  logic       active;
  logic       done;

  int checks;
  int failures;

  // behavioural model state
  logic [2:0] m_ph;
  logic [3:0] m_lv;
  int         m_wait;
  bit         m_gq;
  bit         m_done;

  adsr_phase_controller #(.LEVEL_W(4), .RATE_W(4)) dut (
    .clk(clk), .reset(reset), .tick(tick), .gate(gate),
    .attack_rate(attack_rate), .decay_rate(decay_rate),
    .sustain_level(sustain_level), .release_rate(release_rate),
    .level(level), .phase(phase), .active(active), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_ph = 3'd0; m_lv = 4'd0; m_wait = 0; m_gq = 1'b0; m_done = 1'b0;
  endtask

  // One clock edge of the envelope, applied from the inputs present at the edge.
  task automatic model_clk();
    bit rise, fall;
    rise = gate && !m_gq;
    fall = !gate && m_gq;
    m_done = 1'b0;
    if (!reset) begin
      model_reset();
      return;
    end
    m_gq = gate;
    if (rise) begin
      m_ph = 3'd1; m_wait = attack_rate;
    end else if (fall && (m_ph inside {3'd1, 3'd2, 3'd3})) begin
      m_ph = 3'd4; m_wait = release_rate;
    end else if (tick) begin
      if (m_ph == 3'd3) m_lv = sustain_level;
      else if (m_ph == 3'd0) m_lv = 4'd0;
      else if (m_wait > 0) m_wait = m_wait - 1;
      else begin
        case (m_ph)
          3'd1: begin
            if (m_lv < 4'd15) m_lv = m_lv + 4'd1;
            if (m_lv == 4'd15) begin m_ph = 3'd2; m_wait = decay_rate; end
            else m_wait = attack_rate;
          end
          3'd2: begin
            if (m_lv > sustain_level) m_lv = m_lv - 4'd1;
            if (m_lv <= sustain_level) m_ph = 3'd3;
            m_wait = decay_rate;
          end
          3'd4: begin
            if (m_lv > 4'd0) m_lv = m_lv - 4'd1;
            if (m_lv == 4'd0) begin m_ph = 3'd0; m_done = 1'b1; end
            m_wait = release_rate;
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic cycle(input bit g, input bit t);
    gate = g;
    tick = t;
    @(posedge clk);
    model_clk();
    #1;
  endtask

  task automatic go_idle();
    for (int k = 0; k < 400 && m_ph != 3'd0; k++) cycle(1'b0, 1'b1);
    if (m_ph != 3'd0) begin
      checks++; failures++;
      $display("FAIL go_idle model did not reach idle, phase=%0d", m_ph);
    end
    cycle(1'b0, 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b0; gate = 1'b1;
    attack_rate = 4'd0; decay_rate = 4'd0; sustain_level = 4'd8; release_rate = 4'd0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      tick = i[0];
      @(posedge clk); #1;
      checks++;
      if ({level, phase, active, done} !== {4'd0, 3'd0, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL reset_hold i=%0d got l=%0d p=%0d a=%0b d=%0b want all zero",
                 i, level, phase, active, done);
      end
    end
    reset = 1'b1;
    cycle(1'b1, 1'b0);
    checks++;
    if (phase !== 3'd1 || level !== 4'd0 || active !== 1'b1) begin
      failures++;
      $display("FAIL reset_release got p=%0d l=%0d a=%0b want p=1 l=0 a=1", phase, level, active);
    end
  endtask

  task automatic test_full_cycle();
    int n_done;
    go_idle();
    attack_rate = 4'd0; decay_rate = 4'd1; sustain_level = 4'd8; release_rate = 4'd0;
    n_done = 0;
    for (int i = 0; i < 65; i++) begin
      cycle(i < 50, 1'b1);
      if (done) n_done++;
      checks++;
      if ({level, phase, active, done} !== {m_lv, m_ph, m_ph != 3'd0, m_done}) begin
        failures++;
        $display("FAIL full_cycle i=%0d got l=%0d p=%0d a=%0b d=%0b want l=%0d p=%0d a=%0b d=%0b",
                 i, level, phase, active, done, m_lv, m_ph, m_ph != 3'd0, m_done);
      end
      if (i == 15) begin
        checks++;
        if (level !== 4'd15 || phase !== 3'd2) begin
          failures++;
          $display("FAIL full_peak got l=%0d p=%0d want l=15 p=2", level, phase);
        end
      end
      if (i == 49) begin
        checks++;
        if (level !== 4'd8 || phase !== 3'd3) begin
          failures++;
          $display("FAIL full_sustain got l=%0d p=%0d want l=8 p=3", level, phase);
        end
      end
    end
    checks++;
    if (n_done != 1 || phase !== 3'd0) begin
      failures++;
      $display("FAIL full_done got pulses=%0d p=%0d want pulses=1 p=0", n_done, phase);
    end
  endtask

  task automatic test_rate_pacing();
    go_idle();
    attack_rate = 4'd3; decay_rate = 4'd0; sustain_level = 4'd2; release_rate = 4'd0;
    for (int i = 0; i < 120; i++) begin
      if (i == 50) attack_rate = 4'd0;
      cycle(1'b1, (i % 4) == 3);
      checks++;
      if ({level, phase, active, done} !== {m_lv, m_ph, m_ph != 3'd0, m_done}) begin
        failures++;
        $display("FAIL rate_pacing i=%0d got l=%0d p=%0d a=%0b d=%0b want l=%0d p=%0d a=%0b d=%0b",
                 i, level, phase, active, done, m_lv, m_ph, m_ph != 3'd0, m_done);
      end
      if (i == 34) begin
        checks++;
        if (level !== 4'd2) begin
          failures++;
          $display("FAIL rate_16clk got l=%0d want l=2", level);
        end
      end
    end
  endtask

  task automatic test_retrigger();
    int n_done;
    go_idle();
    attack_rate = 4'd0; decay_rate = 4'd0; sustain_level = 4'd12; release_rate = 4'd0;
    n_done = 0;
    for (int i = 0; i < 50; i++) begin
      cycle(!(i >= 30 && i < 36), 1'b1);
      if (done) n_done++;
      checks++;
      if ({level, phase, active, done} !== {m_lv, m_ph, m_ph != 3'd0, m_done}) begin
        failures++;
        $display("FAIL retrigger i=%0d got l=%0d p=%0d a=%0b d=%0b want l=%0d p=%0d a=%0b d=%0b",
                 i, level, phase, active, done, m_lv, m_ph, m_ph != 3'd0, m_done);
      end
      if (i == 30 || i == 36) begin
        checks++;
        if (phase !== ((i == 30) ? 3'd4 : 3'd1) || level !== ((i == 30) ? 4'd12 : 4'd7)) begin
          failures++;
          $display("FAIL retrigger_edge i=%0d got p=%0d l=%0d", i, phase, level);
        end
      end
    end
    checks++;
    if (n_done != 0) begin
      failures++;
      $display("FAIL retrigger_no_done got pulses=%0d want 0", n_done);
    end
  endtask

  task automatic test_simultaneous();
    go_idle();
    attack_rate = 4'd2; decay_rate = 4'd0; sustain_level = 4'd0; release_rate = 4'd0;
    for (int i = 0; i < 6; i++) begin
      cycle(i < 5, 1'b1);
      checks++;
      if ({level, phase, active, done} !== {m_lv, m_ph, m_ph != 3'd0, m_done}) begin
        failures++;
        $display("FAIL simultaneous i=%0d got l=%0d p=%0d a=%0b d=%0b want l=%0d p=%0d a=%0b d=%0b",
                 i, level, phase, active, done, m_lv, m_ph, m_ph != 3'd0, m_done);
      end
    end
    checks++;
    if (phase !== 3'd4 || level !== 4'd1) begin
      failures++;
      $display("FAIL simultaneous_fall got p=%0d l=%0d want p=4 l=1", phase, level);
    end
  endtask

  task automatic test_edge_cases();
    go_idle();
    attack_rate = 4'd0; decay_rate = 4'd3; sustain_level = 4'd15; release_rate = 4'd3;
    for (int i = 0; i < 56; i++) begin
      sustain_level = (i >= 30) ? 4'd4 : 4'd15;
      cycle(i < 50, 1'b1);
      checks++;
      if ({level, phase, active, done} !== {m_lv, m_ph, m_ph != 3'd0, m_done}) begin
        failures++;
        $display("FAIL edge i=%0d got l=%0d p=%0d a=%0b d=%0b want l=%0d p=%0d a=%0b d=%0b",
                 i, level, phase, active, done, m_lv, m_ph, m_ph != 3'd0, m_done);
      end
      if (i == 19 || i == 30) begin
        checks++;
        if (phase !== 3'd3 || level !== ((i == 19) ? 4'd15 : 4'd4)) begin
          failures++;
          $display("FAIL edge_sustain i=%0d got p=%0d l=%0d", i, phase, level);
        end
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({level, phase, active, done} !== {4'd0, 3'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL edge_async_reset got l=%0d p=%0d a=%0b d=%0b want all zero",
               level, phase, active, done);
    end
    model_reset();
    cycle(1'b0, 1'b1);
    reset = 1'b1;
    cycle(1'b0, 1'b1);
    checks++;
    if ({level, phase, active, done} !== {4'd0, 3'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL edge_after_reset got l=%0d p=%0d a=%0b d=%0b want all zero",
               level, phase, active, done);
    end
  endtask

  task automatic test_random();
    bit g;
    g = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (i % 150 == 0) begin
        attack_rate  = 4'($urandom_range(0, 3));
        decay_rate   = 4'($urandom_range(0, 3));
        release_rate = 4'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 39) == 0) sustain_level = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 24) == 0) g = !g;
      cycle(g, $urandom_range(0, 1) == 1);
      checks++;
      if ({level, phase, active, done} !== {m_lv, m_ph, m_ph != 3'd0, m_done}) begin
        failures++;
        $display("FAIL random i=%0d got l=%0d p=%0d a=%0b d=%0b want l=%0d p=%0d a=%0b d=%0b",
                 i, level, phase, active, done, m_lv, m_ph, m_ph != 3'd0, m_done);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    tick = 1'b0;
    test_reset();
    test_full_cycle();
    test_rate_pacing();
    test_retrigger();
    test_simultaneous();
    test_edge_cases();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
